imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the asynchronous-read IMEM (11-bit word address, 32-bit instruction out).
- Owns the fetch PC and converts it to the IMEM word address.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects from branches and jumps by flushing and refetching. Sits between the IMEM instance and the CPU decode stage.

Parameters:
- RESET_PC, 32'h0040_0000, fetch PC after reset; also the IMEM base address.
- ADDR_W, 11, IMEM word-address width.
- BUF_DEPTH, 2, FIFO entries; must be a power of 2, range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- im_addr  output  ADDR_W  IMEM word address, equal to ((fetch_pc - RESET_PC) >> 2) truncated to ADDR_W; combinational from fetch_pc.
- im_rdata  input  32  IMEM instruction word; valid combinationally in the same cycle as im_addr.
- redirect_valid  input  1  branch/jump taken; flush and restart this cycle.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- inst_valid  output  1  FIFO head is valid.
- inst_ready  input  1  decode accepts the head.
- inst_word  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.
- fetch_pc  output  32  PC currently presented to IMEM.
- buf_count  output  $clog2(BUF_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC, buf_count = 0, inst_valid = 0, inst_word = 0, inst_pc = 0.
  - FIFO pointers = 0; FIFO storage contents are don't-care.
  - Reset asserted mid-operation discards all buffered words with no further output.
- pop = inst_valid & inst_ready & ~redirect_valid.
- push = ~redirect_valid & (buf_count < BUF_DEPTH | pop).
  - Push when full is allowed only together with a pop in the same cycle.
- On push: write {fetch_pc, im_rdata} at the write pointer, then fetch_pc += 4 (32-bit wrap).
- On pop: advance the read pointer.
- buf_count updates by +push −pop.
- Priority is redirect > push/pop. On redirect_valid at a clock edge:
  - buf_count = 0 and pointers = 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No push and no pop occur that cycle.
  - inst_valid is 0 in the following cycle.
- Latency:
  - The first word is pushed at the first rising edge after rst deasserts; inst_valid = 1 from that edge onward.
  - Redirect-to-valid latency is one edge for the redirect plus one edge for the push.
- Throughput: one instruction per cycle sustained while inst_ready = 1. BUF_DEPTH ≥ 2 means there is no bubble after a single stall cycle.
- inst_valid = (buf_count != 0). inst_word and inst_pc come from the FIFO head; they are registered storage, not combinational from im_rdata.
- Boundaries:
  - im_addr wraps modulo 2^ADDR_W; no error is raised.
  - fetch_pc below RESET_PC produces a wrapped im_addr; this is not checked.
  - Full with inst_ready = 0: fetch_pc holds and im_addr is stable.
  - Empty with inst_ready = 1: no pop, no underflow.

Optional Feature:
- Macro IMEM_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on every push) and perf_flush_cnt[31:0] (increments on each redirect that discards buf_count > 0 entries).
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then inst_ready = 1, with the IMEM model returning word = 32'hA000_0000 + addr:
  - Inst_valid is 1 after the first edge.
  - Successive inst_pc values are 0x0040_0000, 0x0040_0004, 0x0040_0008 with inst_word A000_0000, A000_0001, A000_0002.
  - im_addr is 0, 1, 2, 3…
- inst_ready = 0 for 5 cycles from reset:
  - buf_count reaches 2 and holds.
  - fetch_pc holds at 0x0040_0008.
  - On release, output continues with no gap or duplicate (pc 0x0040_0000, 0x0040_0004, 0x0040_0008 in consecutive cycles).
- Redirect with the buffer full, redirect_pc = 0x0040_0103:
  - Next cycle buf_count = 0 and inst_valid = 0; fetch_pc = 0x0040_0100.
  - One edge later inst_pc = 0x0040_0100, inst_word = A000_0040.
- redirect_valid and inst_ready both high with the buffer non-empty: no pop occurs; the flush wins and buf_count = 0.
- fetch_pc = 0x0040_1FFC (im_addr 0x7FF), then +4:
  - im_addr = 0x000 and fetch_pc = 0x0040_2000.
- Assert rst asynchronously mid-cycle while buf_count = 2: outputs drop to reset values immediately, before the next clock edge.
- With IMEM_FETCH_PERF_EN: 10 pushes and then 1 redirect with 2 entries buffered → perf_fetch_cnt = 10, perf_flush_cnt = 1.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the async-read IMEM and buffers words for decode.
// Optional performance counters are compiled in with `define IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          ADDR_W    = 11,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            im_addr,
  input  logic [31:0]                  im_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [31:0]                  inst_word,
  output logic [31:0]                  inst_pc,
  output logic [31:0]                  fetch_pc,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]                  perf_fetch_cnt,
  output logic [31:0]                  perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             push, pop;
  logic [31:0]      pc_offset;

  logic [31:0] pc_mem   [BUF_DEPTH];
  logic [31:0] word_mem [BUF_DEPTH];

  assign pc_offset = pc_reg - RESET_PC;
  assign im_addr   = pc_offset[ADDR_W+1:2];
  assign fetch_pc  = pc_reg;
  assign buf_count = count_reg;

  // Head is read straight out of the buffer; zeroed while empty so reset shows clean outputs.
  assign inst_valid = (count_reg != '0);
  assign inst_word  = inst_valid ? word_mem[rd_ptr_reg] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

  always_comb begin
    pop         = inst_valid & inst_ready & ~redirect_valid;
    push        = ~redirect_valid & ((count_reg < DEPTH_C) | pop);
    pc_next     = pc_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (redirect_valid) begin
      pc_next     = {redirect_pc[31:2], 2'b00};
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      word_mem[wr_ptr_reg] <= im_rdata;
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (push && fetch_cnt_reg != 32'hFFFF_FFFF) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      // Only redirects that actually throw away buffered words count as flushes.
      if (redirect_valid && count_reg != '0 && flush_cnt_reg != 32'hFFFF_FFFF) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a reference model predicts pushes, and popped heads are compared.
// Performance-counter checks compile in with `define IMEM_FETCH_PERF_EN.
module tb_imem_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;
  logic [1:0]  buf_count;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .fetch_pc       (fetch_pc),
    .buf_count      (buf_count)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // IMEM model: word = A000_0000 + word address
  assign im_rdata = 32'hA000_0000 + {21'h0, im_addr};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [31:0] pc);
    logic [31:0] d;
    d = (pc - RPC) >> 2;
    return d & 32'h0000_07FF;
  endfunction

  task automatic model_reset();
    m_pc    = RPC;
    m_fetch = 0;
    m_flush = 0;
    exp_q.delete();
  endtask

  // One clock: compare at the falling edge, advance the model for the coming rising edge.
  task automatic step();
    logic        pop_c, push_c;
    logic [63:0] head;
    @(negedge clk);
    check("fetch_pc", fetch_pc, m_pc);
    check("im_addr", im_addr, addr_of(m_pc));
    check("buf_count", buf_count, exp_q.size());
    check("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("inst_pc", inst_pc, head[63:32]);
      check("inst_word", inst_word, head[31:0]);
    end
`ifdef IMEM_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_flush", perf_flush_cnt, m_flush);
`endif
    pop_c  = (exp_q.size() != 0) && inst_ready && !redirect_valid;
    push_c = !redirect_valid && ((exp_q.size() < 2) || pop_c);
    if (redirect_valid) begin
      if (exp_q.size() != 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      $display("redirect to %h", m_pc);
    end else begin
      if (pop_c) begin
        head = exp_q[0];
        $display("pop pc=%h word=%h", head[63:32], head[31:0]);
        void'(exp_q.pop_front());
      end
      if (push_c) begin
        exp_q.push_back({m_pc, 32'hA000_0000 + addr_of(m_pc)});
        m_pc = m_pc + 32'd4;
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs clear before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", inst_valid, 1'b0);
    check("arst_count", buf_count, 2'd0);
    check("arst_fetch_pc", fetch_pc, RPC);
    check("arst_inst_pc", inst_pc, 32'h0);
    check("arst_inst_word", inst_word, 32'h0);
    model_reset();
    release_rst();
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    model_reset();
    #12;
    check("rst_valid", inst_valid, 1'b0);
    check("rst_count", buf_count, 2'd0);
    check("rst_fetch_pc", fetch_pc, RPC);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_word", inst_word, 32'h0);
    check("rst_im_addr", im_addr, 11'h0);
    release_rst();

    // streaming with decode always ready
    step();
    check("first_valid", inst_valid, 1'b1);
    steps(6);

    // stall five cycles from reset, then release
    async_reset();
    inst_ready = 1'b0;
    steps(5);
    check("stall_count", buf_count, 2'd2);
    check("stall_fetch_pc", fetch_pc, 32'h0040_0008);
    inst_ready = 1'b1;
    steps(3);

    // redirect while full and decode ready: flush wins
    inst_ready = 1'b0;
    steps(2);
    check("pre_redir_count", buf_count, 2'd2);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    step();
    check("redir_count", buf_count, 2'd0);
    check("redir_valid", inst_valid, 1'b0);
    check("redir_fetch_pc", fetch_pc, 32'h0040_0100);
    redirect_valid = 1'b0;
    step();
    check("redir_inst_pc", inst_pc, 32'h0040_0100);
    check("redir_inst_word", inst_word, 32'hA000_0040);
    steps(2);

    // IMEM address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_1FFC;
    step();
    check("wrap_addr_hi", im_addr, 11'h7FF);
    redirect_valid = 1'b0;
    step();
    check("wrap_addr_lo", im_addr, 11'h000);
    check("wrap_fetch_pc", fetch_pc, 32'h0040_2000);
    check("wrap_inst_word", inst_word, 32'hA000_07FF);
    steps(2);

    // async reset with a full buffer
    inst_ready = 1'b0;
    steps(3);
    check("pre_arst_count", buf_count, 2'd2);
    async_reset();

    // 10 pushes, then a redirect discarding 2 entries
    inst_ready = 1'b0;
    steps(2);
    inst_ready = 1'b1;
    steps(8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0200;
    step();
    redirect_valid = 1'b0;
`ifdef IMEM_FETCH_PERF_EN
    check("perf_fetch_10", perf_fetch_cnt, 32'd10);
    check("perf_flush_1", perf_flush_cnt, 32'd1);
`endif

    // random mix of stalls and redirects
    for (int i = 0; i < 40; i++) begin
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = RPC + 32'($urandom_range(0, 16383));
      step();
    end
    redirect_valid = 1'b0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
